gshare_bp: RTL and testbench
============================

# gshare_bp

Parametrised next-generation branch predictor for the fetch stage.
- Combines a gshare direction table of 2-bit counters with a direct-mapped branch target buffer (BTB).
- Keeps a speculative global history register (GHR) that is repaired on misprediction from the history snapshot the branch carried down the pipe.
- Clears its pattern history table (PHT) with a sequential walk after reset.
- Fetch queries it every cycle; execute sends one resolution per cycle.

## Interface
- HIST_WIDTH, 8, GHR width; must satisfy 2 ≤ HIST_WIDTH ≤ PHT_IDX_WIDTH
- PHT_IDX_WIDTH, 8, PHT index bits; PHT depth = 2^PHT_IDX_WIDTH
- BTB_IDX_WIDTH, 4, BTB index bits; BTB depth = 2^BTB_IDX_WIDTH
- TAG_WIDTH, 8, BTB tag bits, taken from pc[BTB_IDX_WIDTH+TAG_WIDTH+1 : BTB_IDX_WIDTH+2]
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- pred_valid  in  1  fetch presents pred_pc this cycle
- pred_pc  in  32  fetch PC
- pred_taken  out  1  predicted taken
- pred_hit  out  1  BTB hit (pred_pc is a known branch)
- pred_target  out  32  predicted next PC
- pred_hist  out  HIST_WIDTH  GHR value used for this prediction; fetch carries it with the instruction
- upd_valid  in  1  execute resolves a branch this cycle
- upd_pc  in  32  resolved branch PC
- upd_taken  in  1  actual direction
- upd_target  in  32  actual taken target
- upd_hist  in  HIST_WIDTH  pred_hist snapshot returned with the branch
- upd_mispred  in  1  direction or target mispredicted; qualified by upd_valid
- busy  out  1  PHT initialisation in progress

## Operation
- FSM states:
  - INIT: entered when reset=1, from any state, including mid-walk.
  - RUN.
- Reset cycle:
  - GHR=0, all BTB valid bits=0, init counter=0, state=INIT.
- INIT:
  - Each cycle writes PHT[init_cnt]=2'b10 (weakly taken) and increments init_cnt.
  - After writing index 2^PHT_IDX_WIDTH−1, moves to RUN.
  - busy=1; pred_taken=0 and pred_hit=0; updates ignored.
- Index computation:
  - idx = pc[PHT_IDX_WIDTH+1:2] XOR {zeros, hist}, with hist zero-extended into the LSBs.
  - Predict uses GHR; update uses upd_hist.
- Prediction, combinational:
  - hit = BTB valid && tag match.
  - pred_taken = hit && PHT[idx][1].
  - pred_target = pred_taken ? BTB target : pred_pc+4 (mod 2^32).
- Speculative history:
  - In RUN, if pred_valid && hit: GHR <= {GHR[HIST_WIDTH-2:0], pred_taken}.
- Resolution, in RUN when upd_valid:
  - PHT[idx(upd_pc, upd_hist)] saturating update: taken increments (11 stays 11); not-taken decrements (00 stays 00).
  - upd_taken: BTB[upd_pc index] <= {valid=1, tag, upd_target}, overwriting any alias.
  - Not-taken: BTB unchanged.
  - upd_mispred: GHR <= {upd_hist[HIST_WIDTH-2:0], upd_taken}. This overrides a same-cycle speculative shift.
- Simultaneous predict and update to the same PHT or BTB entry:
  - The prediction sees the pre-update value.

## Timing
- Reset values:
  - busy=1, pred_taken=0, pred_hit=0.
  - pred_hist=0.
  - pred_target=pred_pc+4.
- busy falls exactly 2^PHT_IDX_WIDTH cycles after the first cycle with reset=0.
- Prediction latency 0 (combinational from pred_pc and state).
- State written at a clock edge is visible to predictions in the following cycle.
- No handshake or backpressure: one prediction and one update accepted per cycle.

## Structure
- Package bp_pkg:
  - Counter encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
  - ctr_next(ctr, taken) saturating function.
  - FSM state enum {INIT, RUN}.
- Sub-module bp_btb:
  - Direct-mapped valid/tag/target array.
  - One combinational read port and one synchronous write port.
  - Synchronous clear of the valid bits.
- PHT, GHR and FSM live in gshare_bp.

## Test plan
- Reset walk, defaults: reset 1 cycle, then idle. busy=1 for exactly 256 cycles, then 0. After that, pred_pc=0x100 gives pred_hit=0, pred_target=0x104.
- Training, defaults: upd_valid with pc=0x200, taken, target 0x400, hist=0. Then pred_pc=0x200 with GHR=0 gives hit=1, taken=1 (10→11), target=0x400. After two not-taken updates at the same index, pred_taken=0.
- Saturation:
  - Five taken updates on one index leave the counter at 11; a single not-taken update → 10, pred_taken still 1.
  - Five not-taken updates leave it at 00.
- Speculative history and repair:
  - Three predicted-taken hits take GHR from 0 to 0b111.
  - Then upd_mispred with upd_hist=0x05, upd_taken=0, together with a pred hit in the same cycle. Next cycle GHR=0x0A, i.e. the repair wins.
- Collision: same-cycle predict and update at 0x200 (counter 01, update taken). Prediction that cycle gives taken=0; the next cycle gives taken=1.
- Mid-walk reset: assert reset at walk cycle 100. The walk restarts, busy stays high 256 cycles after release, and updates during INIT leave the PHT at 10.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and helpers for the gshare branch predictor.
package bp_pkg;

  // 2-bit direction counter encodings
  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // INIT walks the PHT after reset; RUN predicts and trains
  typedef enum logic {
    INIT,
    RUN
  } bp_state_e;

  // Saturating counter step toward the resolved direction
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    case (ctr)
      SNT:     nxt = taken ? WNT : SNT;
      WNT:     nxt = taken ? WT  : SNT;
      WT:      nxt = taken ? ST  : WNT;
      ST:      nxt = taken ? ST  : WT;
      default: nxt = ctr;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer: valid/tag/target per entry,
// one combinational read port, one synchronous write port, sync clear of valids.
module bp_btb #(
  parameter int IDX_WIDTH = 4,
  parameter int TAG_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic [IDX_WIDTH-1:0] rd_idx,
  input  logic [TAG_WIDTH-1:0] rd_tag,
  output logic                 rd_hit,
  output logic [31:0]          rd_target,
  input  logic                 wr_en,
  input  logic [IDX_WIDTH-1:0] wr_idx,
  input  logic [TAG_WIDTH-1:0] wr_tag,
  input  logic [31:0]          wr_target
);

  localparam int DEPTH = 1 << IDX_WIDTH;

  logic [DEPTH-1:0]     valid;
  logic [TAG_WIDTH-1:0] tags    [DEPTH];
  logic [31:0]          targets [DEPTH];

  // Valid bits: cleared on reset, set when an entry is written
  always_ff @(posedge clk) begin
    if (clear) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Tag and target storage
  // NOTE: the storage arrays have no reset; the valid bits alone decide
  // whether an entry means anything, so clearing them is sufficient.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_idx]    <= wr_tag;
      targets[wr_idx] <= wr_target;
    end
  end

  // Combinational lookup
  always_comb begin
    rd_hit    = valid[rd_idx] && (tags[rd_idx] == rd_tag);
    rd_target = targets[rd_idx];
  end

endmodule

// File: rtl/gshare_bp.sv
// Gshare direction predictor + BTB with speculative global history,
// misprediction repair and a post-reset PHT initialisation walk.
module gshare_bp
  import bp_pkg::*;
#(
  parameter int HIST_WIDTH    = 8,
  parameter int PHT_IDX_WIDTH = 8,
  parameter int BTB_IDX_WIDTH = 4,
  parameter int TAG_WIDTH     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pred_valid,
  input  logic [31:0]           pred_pc,
  output logic                  pred_taken,
  output logic                  pred_hit,
  output logic [31:0]           pred_target,
  output logic [HIST_WIDTH-1:0] pred_hist,
  input  logic                  upd_valid,
  input  logic [31:0]           upd_pc,
  input  logic                  upd_taken,
  input  logic [31:0]           upd_target,
  input  logic [HIST_WIDTH-1:0] upd_hist,
  input  logic                  upd_mispred,
  output logic                  busy
);

  localparam int PHT_DEPTH = 1 << PHT_IDX_WIDTH;
  localparam int TAG_LSB   = BTB_IDX_WIDTH + 2;
  localparam int TAG_MSB   = BTB_IDX_WIDTH + TAG_WIDTH + 1;

  bp_state_e                state, state_next;
  logic [PHT_IDX_WIDTH-1:0] init_cnt;
  logic [HIST_WIDTH-1:0]    ghr;
  logic [1:0]               pht [PHT_DEPTH];

  logic                     run;
  logic                     upd_en;
  logic [PHT_IDX_WIDTH-1:0] pred_idx, upd_idx;
  logic                     btb_hit;
  logic [31:0]              btb_target;

  // Upper and lower PC bits that neither table indexes
  logic unused_upd_pc;
  assign unused_upd_pc = ^upd_pc;

  // gshare index: word-aligned PC bits XOR history placed in the LSBs
  function automatic logic [PHT_IDX_WIDTH-1:0] pht_index(input logic [31:0] pc,
                                                         input logic [HIST_WIDTH-1:0] hist);
    logic [PHT_IDX_WIDTH-1:0] hist_ext;
    hist_ext = '0;
    hist_ext[HIST_WIDTH-1:0] = hist;
    return pc[PHT_IDX_WIDTH+1:2] ^ hist_ext;
  endfunction

  assign pred_idx = pht_index(pred_pc, ghr);
  assign upd_idx  = pht_index(upd_pc, upd_hist);
  assign upd_en   = run && upd_valid && !reset;

  bp_btb #(
    .IDX_WIDTH (BTB_IDX_WIDTH),
    .TAG_WIDTH (TAG_WIDTH)
  ) u_btb (
    .clk       (clk),
    .clear     (reset),
    .rd_idx    (pred_pc[BTB_IDX_WIDTH+1:2]),
    .rd_tag    (pred_pc[TAG_MSB:TAG_LSB]),
    .rd_hit    (btb_hit),
    .rd_target (btb_target),
    .wr_en     (upd_en && upd_taken),
    .wr_idx    (upd_pc[BTB_IDX_WIDTH+1:2]),
    .wr_tag    (upd_pc[TAG_MSB:TAG_LSB]),
    .wr_target (upd_target)
  );

  // FSM state register
  // NOTE: every clocked block uses non-blocking assignments so all registers
  // sample pre-edge values and simulation matches the synthesised flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state: leave INIT once the last PHT entry has been written
  always_comb begin
    // NOTE: default assignment first so no path leaves state_next unassigned,
    // which would infer a latch.
    state_next = state;
    case (state)
      INIT:    if (init_cnt == '1) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = INIT;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state == INIT);
    run  = (state == RUN);
  end

  // Initialisation walk pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      init_cnt <= '0;
    end else if (state == INIT) begin
      init_cnt <= init_cnt + PHT_IDX_WIDTH'(1);
    end
  end

  // PHT: weakly-taken fill during INIT, saturating training during RUN
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == INIT) begin
        pht[init_cnt] <= WT;
      end else if (upd_en) begin
        pht[upd_idx] <= ctr_next(pht[upd_idx], upd_taken);
      end
    end
  end

  // Global history: repair on mispredict beats the speculative shift
  always_ff @(posedge clk) begin
    if (reset) begin
      ghr <= '0;
    end else if (upd_en && upd_mispred) begin
      ghr <= {upd_hist[HIST_WIDTH-2:0], upd_taken};
    end else if (run && pred_valid && pred_hit) begin
      ghr <= {ghr[HIST_WIDTH-2:0], pred_taken};
    end
  end

  // Prediction outputs, combinational from pred_pc and current state
  always_comb begin
    pred_hit    = run && btb_hit;
    pred_taken  = pred_hit && pht[pred_idx][1];
    pred_target = pred_taken ? btb_target : pred_pc + 32'd4;
    pred_hist   = ghr;
  end

endmodule

// File: tb/tb_gshare_bp.sv
// Directed, table-driven bench for gshare_bp with default parameters.
module tb_gshare_bp;

  logic        clk = 1'b0;
  logic        reset;
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic        pred_hit;
  logic [31:0] pred_target;
  logic [7:0]  pred_hist;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [7:0]  upd_hist;
  logic        upd_mispred;
  logic        busy;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  gshare_bp dut (
    .clk         (clk),
    .reset       (reset),
    .pred_valid  (pred_valid),
    .pred_pc     (pred_pc),
    .pred_taken  (pred_taken),
    .pred_hit    (pred_hit),
    .pred_target (pred_target),
    .pred_hist   (pred_hist),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target),
    .upd_hist    (upd_hist),
    .upd_mispred (upd_mispred),
    .busy        (busy)
  );

  // One row: optional one-cycle update, then a prediction query (GHR stays 0)
  typedef struct {
    logic        do_upd;
    logic [31:0] upc;
    logic        utaken;
    logic [31:0] utgt;
    logic [7:0]  uhist;
    logic [31:0] ppc;
    logic        ehit;
    logic        etaken;
    logic [31:0] etgt;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(input logic du, input logic [31:0] upc, input logic ut,
                              input logic [31:0] utgt, input logic [7:0] uh,
                              input logic [31:0] ppc, input logic eh, input logic et,
                              input logic [31:0] etgt);
    vec_t v;
    v.do_upd = du;  v.upc = upc;  v.utaken = ut;  v.utgt = utgt;  v.uhist = uh;
    v.ppc = ppc;    v.ehit = eh;  v.etaken = et;  v.etgt = etgt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    pred_valid = 1'b0; pred_pc = 32'h0;
    upd_valid = 1'b0; upd_pc = 32'h0; upd_taken = 1'b0;
    upd_target = 32'h0; upd_hist = 8'h0; upd_mispred = 1'b0;
  endtask

  task automatic update(input logic [31:0] pc, input logic t, input logic [31:0] tgt,
                        input logic [7:0] h, input logic m);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = t;
    upd_target = tgt; upd_hist = h; upd_mispred = m;
    tick();
    upd_valid = 1'b0; upd_mispred = 1'b0;
  endtask

  task automatic predict_check(input string tag, input logic [31:0] pc, input logic eh,
                               input logic et, input logic [31:0] etgt, input logic [7:0] ehist);
    pred_pc = pc;
    #1;
    check({tag, "_hit"},    32'(pred_hit),   32'(eh));
    check({tag, "_taken"},  32'(pred_taken), 32'(et));
    check({tag, "_target"}, pred_target,     etgt);
    check({tag, "_hist"},   32'(pred_hist),  32'(ehist));
  endtask

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;

    vecs[0]  = mk(0, 32'h0,   0, 32'h0,   8'h00, 32'h100, 0, 0, 32'h104);
    vecs[1]  = mk(1, 32'h200, 1, 32'h400, 8'h00, 32'h200, 1, 1, 32'h400); // 10->11
    vecs[2]  = mk(1, 32'h200, 0, 32'h0,   8'h00, 32'h200, 1, 1, 32'h400); // 11->10
    vecs[3]  = mk(1, 32'h200, 0, 32'h0,   8'h00, 32'h200, 1, 0, 32'h204); // 10->01
    vecs[4]  = mk(1, 32'h200, 0, 32'h0,   8'h00, 32'h200, 1, 0, 32'h204); // 01->00
    vecs[5]  = mk(1, 32'h204, 1, 32'h800, 8'h01, 32'h204, 1, 1, 32'h800); // trains idx 0x80
    vecs[6]  = mk(1, 32'h200, 1, 32'h400, 8'h00, 32'h200, 1, 1, 32'h400); // 01->10
    vecs[7]  = mk(1, 32'h300, 1, 32'h600, 8'h00, 32'h200, 0, 0, 32'h204); // BTB alias evicts 0x200
    for (int i = 8; i <= 11; i++)
      vecs[i] = mk(1, 32'h300, 1, 32'h600, 8'h00, 32'h300, 1, 1, 32'h600); // saturate at 11
    vecs[12] = mk(1, 32'h300, 0, 32'h0,   8'h00, 32'h300, 1, 1, 32'h600); // 11->10
    for (int i = 13; i <= 16; i++)
      vecs[i] = mk(1, 32'h300, 0, 32'h0,   8'h00, 32'h300, 1, 0, 32'h304); // down to 00
    vecs[17] = mk(1, 32'h300, 1, 32'h600, 8'h00, 32'h300, 1, 0, 32'h304); // 00->01

    // Reset and initialisation walk
    clear_in();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    pred_pc = 32'h100;
    #1;
    check("rst_busy",   32'(busy),       32'd1);
    check("rst_hit",    32'(pred_hit),   32'd0);
    check("rst_taken",  32'(pred_taken), 32'd0);
    check("rst_hist",   32'(pred_hist),  32'd0);
    check("rst_target", pred_target,     32'h104);
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      tick();
      n++;
    end
    check("walk_cycles", n, 256);

    // Table-driven training and prediction
    for (int i = 0; i < 18; i++) begin
      if (vecs[i].do_upd)
        update(vecs[i].upc, vecs[i].utaken, vecs[i].utgt, vecs[i].uhist, 1'b0);
      predict_check($sformatf("row%0d", i), vecs[i].ppc, vecs[i].ehit,
                    vecs[i].etaken, vecs[i].etgt, 8'h00);
    end

    // Speculative history: three taken hits on 0x204 give GHR 0b111
    pred_valid = 1'b1;
    predict_check("spec0", 32'h204, 1, 1, 32'h800, 8'h00);
    tick();
    predict_check("spec1", 32'h204, 1, 1, 32'h800, 8'h01);
    tick();
    predict_check("spec2", 32'h204, 1, 1, 32'h800, 8'h03);
    tick();
    #1;
    check("spec3_hist", 32'(pred_hist), 32'h07);
    // Repair and a speculative hit in the same cycle: repair wins
    upd_valid = 1'b1; upd_pc = 32'h1000; upd_taken = 1'b0;
    upd_hist = 8'h05; upd_mispred = 1'b1;
    #1;
    check("repair_same_hit", 32'(pred_hit), 32'd1);
    tick();
    clear_in();
    #1;
    check("repair_hist", 32'(pred_hist), 32'h0A);

    // Bring GHR back to 0, then set idx 0x80 to 01 with 0x200 in the BTB
    update(32'h1000, 1'b0, 32'h0, 8'h00, 1'b1);
    #1;
    check("repair0_hist", 32'(pred_hist), 32'h00);
    update(32'h200, 1'b1, 32'h400, 8'h00, 1'b0); // 10->11
    update(32'h200, 1'b0, 32'h0,   8'h00, 1'b0); // 11->10
    update(32'h200, 1'b0, 32'h0,   8'h00, 1'b0); // 10->01
    // Collision: prediction sees the pre-update counter
    pred_valid = 1'b1;
    upd_valid = 1'b1; upd_pc = 32'h200; upd_taken = 1'b1;
    upd_target = 32'h400; upd_hist = 8'h00;
    predict_check("coll_same", 32'h200, 1, 0, 32'h204, 8'h00);
    tick();
    clear_in();
    predict_check("coll_next", 32'h200, 1, 1, 32'h400, 8'h00);

    // Reset in the middle of the walk; updates during INIT must be ignored
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("mid_busy", 32'(busy), 32'd1);
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      if (n >= 200 && n <= 202) begin
        upd_valid = 1'b1; upd_pc = 32'h004; upd_taken = 1'b0;
        upd_target = 32'h0; upd_hist = 8'h00;
      end else if (n == 203) begin
        upd_valid = 1'b1; upd_pc = 32'h008; upd_taken = 1'b1;
        upd_target = 32'h900; upd_hist = 8'h00;
      end else begin
        upd_valid = 1'b0;
      end
      tick();
      n++;
    end
    clear_in();
    check("mid_walk_cycles", n, 256);
    predict_check("init_btb", 32'h008, 0, 0, 32'h00C, 8'h00);
    update(32'h004, 1'b1, 32'h700, 8'h00, 1'b0); // 10->11 if INIT updates were dropped
    predict_check("init_pht_t", 32'h004, 1, 1, 32'h700, 8'h00);
    update(32'h004, 1'b0, 32'h0, 8'h00, 1'b0);   // 11->10
    predict_check("init_pht_nt", 32'h004, 1, 1, 32'h700, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
